// File: rtl/tsmp_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tsmp_wr_arbiter
//
// Packet-granular round-robin arbiter that shares the write port of one
// small FIFO among NumSrc requesters in the FIFO write clock domain. One
// source is granted at a time and its packet is streamed word by word into
// the FIFO. Writes are gated on FIFO occupancy so the FIFO can never
// overflow. Packets longer than MaxWords are cut: the MaxWords-th word is
// written with its last flag forced, and the remaining words are arbitrated
// later as a new packet.
//
// Ports
//   wrclk         write-domain clock, all logic on the rising edge
//   wr_aclr       asynchronous active-high reset
//   src_data      NumSrc words, source i at [i*DataWidth +: DataWidth];
//                 bit DataWidth-1 of a word is the last-word flag
//   src_valid     source i presents a word
//   src_ready     source i word accepted this cycle (combinational)
//   fifo_wrfull   FIFO write-side full flag
//   fifo_wrusedw  FIFO write-side used-word count
//   fifo_data     registered FIFO write data
//   fifo_wrreq    registered FIFO write request
//   grant_id      index of the granted source, meaningful while busy
//   busy          a packet transfer is in progress
//   pkt_cnt       packets written (truncated ones included), wraps
//   len_err       one-cycle pulse when a packet is truncated
// ---------------------------------------------------------------------------
module tsmp_wr_arbiter #(
    parameter int NumSrc      = 4,
    parameter int DataWidth   = 9,
    parameter int RAMAddWidth = 4,
    parameter int MaxWords    = 64
) (
    input  logic                        wrclk,
    input  logic                        wr_aclr,
    input  logic [NumSrc*DataWidth-1:0] src_data,
    input  logic [NumSrc-1:0]           src_valid,
    output logic [NumSrc-1:0]           src_ready,
    input  logic                        fifo_wrfull,
    input  logic [RAMAddWidth-1:0]      fifo_wrusedw,
    output logic [DataWidth-1:0]        fifo_data,
    output logic                        fifo_wrreq,
    output logic [2:0]                  grant_id,
    output logic                        busy,
    output logic [15:0]                 pkt_cnt,
    output logic                        len_err
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int             OccWidth  = RAMAddWidth + 1;
    localparam logic [OccWidth-1:0] FifoDepth = OccWidth'(1 << RAMAddWidth);
    localparam logic [2:0]     LastInit  = 3'(NumSrc - 1);
    localparam logic [7:0]     WordLimit = 8'(MaxWords - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             grant_nxt;
    logic [2:0]             last_grant;
    logic [2:0]             last_grant_nxt;
    logic [7:0]             word_cnt;
    logic [7:0]             word_cnt_nxt;
    logic [DataWidth-1:0]   data_nxt;
    logic                   wrreq_nxt;
    logic                   len_err_nxt;
    logic [15:0]            pkt_cnt_nxt;

    // -----------------------------------------------------------------------
    // Occupancy gate. The FIFO flags lag wrreq by one cycle, so the write
    // currently on the port is added to the reported count. {full, usedw}
    // reads as 16 when the FIFO is full (usedw wraps to 0 there).
    // -----------------------------------------------------------------------
    logic [OccWidth-1:0] occ;
    logic                space_ok;

    assign occ      = {fifo_wrfull, fifo_wrusedw} + OccWidth'(fifo_wrreq);
    assign space_ok = (occ < FifoDepth);

    // -----------------------------------------------------------------------
    // Granted-source word and valid.
    // -----------------------------------------------------------------------
    logic                 sel_valid;
    logic [DataWidth-1:0] sel_word;

    // NOTE: every signal written in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel_word  = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (grant_id == 3'(i)) begin
                sel_valid = src_valid[i];
                sel_word  = src_data[i*DataWidth +: DataWidth];
            end
        end
    end

    logic accept;
    logic last_flag;
    logic truncate;
    logic pkt_end;

    assign accept    = (state == XFER) && sel_valid && space_ok;
    assign last_flag = sel_word[DataWidth-1];
    // The MaxWords-th word of a packet without its last flag closes the packet.
    assign truncate  = accept && !last_flag && (word_cnt == WordLimit);
    assign pkt_end   = accept && (last_flag || truncate);

    // -----------------------------------------------------------------------
    // Round-robin pick: the valid source with the smallest circular distance
    // after last_grant wins.
    // -----------------------------------------------------------------------
    logic [2:0] rr_pick;
    int         rr_dist;
    int         rr_best;

    always_comb begin
        rr_pick = last_grant;
        rr_dist = 0;
        rr_best = NumSrc;
        for (int i = 0; i < NumSrc; i++) begin
            rr_dist = (i + 2*NumSrc - 1 - int'(last_grant)) % NumSrc;
            if (src_valid[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                rr_pick = 3'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        word_cnt_nxt   = word_cnt;
        data_nxt       = fifo_data;
        wrreq_nxt      = 1'b0;
        len_err_nxt    = 1'b0;
        pkt_cnt_nxt    = pkt_cnt;
        src_ready      = '0;

        case (state)
            IDLE: begin
                // Nothing is accepted here, which guarantees a one-cycle gap
                // between packets and lets last_grant settle before picking.
                if (|src_valid) begin
                    grant_nxt = rr_pick;
                    state_nxt = XFER;
                end
            end

            XFER: begin
                for (int i = 0; i < NumSrc; i++) begin
                    if (grant_id == 3'(i)) begin
                        src_ready[i] = sel_valid && space_ok;
                    end
                end

                // A granted source that drops valid simply stalls the
                // transfer; the grant is held with no timeout.
                if (accept) begin
                    wrreq_nxt    = 1'b1;
                    data_nxt     = sel_word;
                    word_cnt_nxt = word_cnt + 8'd1;
                    if (truncate) begin
                        data_nxt[DataWidth-1] = 1'b1;
                        len_err_nxt           = 1'b1;
                    end
                    if (pkt_end) begin
                        pkt_cnt_nxt    = pkt_cnt + 16'd1;
                        last_grant_nxt = grant_id;
                        word_cnt_nxt   = '0;
                        state_nxt      = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge wrclk or posedge wr_aclr) begin
        if (wr_aclr) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= LastInit;
            word_cnt   <= '0;
            fifo_data  <= '0;
            fifo_wrreq <= 1'b0;
            len_err    <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_grant_nxt;
            word_cnt   <= word_cnt_nxt;
            fifo_data  <= data_nxt;
            fifo_wrreq <= wrreq_nxt;
            len_err    <= len_err_nxt;
            pkt_cnt    <= pkt_cnt_nxt;
        end
    end

    assign busy = (state == XFER);

endmodule

// File: doc/tsmp_wr_arbiter.md
# tsmp_wr_arbiter

Packet-granular round-robin write arbiter that shares the write port of one 9-bit × 16-deep FIFO (ASFIFO_9_16-class) among up to NumSrc requesters in the write clock domain. Each requester presents packets as 9-bit words; bit 8 is the last-word flag. The block grants one source at a time and streams that packet into the FIFO. It gates writes on FIFO occupancy so the FIFO never overflows, and it enforces a maximum packet length.

## Interface
- NumSrc, 4: number of requesters, 2..8.
- DataWidth, 9: word width; bit DataWidth-1 is the last-word flag.
- RAMAddWidth, 4: FIFO usedw width; FIFO depth = 2^RAMAddWidth.
- MaxWords, 64: maximum words per packet, 2..255.

Ports:
- wrclk  in  1  single clock; all logic on its rising edge.
- wr_aclr  in  1  asynchronous, active-high reset.
- src_data  in  NumSrc*DataWidth  source words; source i occupies slice [i*DataWidth +: DataWidth].
- src_valid  in  NumSrc  source i has a word.
- src_ready  out  NumSrc  source i word accepted this cycle (combinational).
- fifo_wrfull  in  1  FIFO write-domain full.
- fifo_wrusedw  in  RAMAddWidth  FIFO write-domain used words.
- fifo_data  out  DataWidth  registered FIFO write data.
- fifo_wrreq  out  1  registered FIFO write request.
- grant_id  out  3  index of the granted source; valid while busy.
- busy  out  1  high in XFER.
- pkt_cnt  out  16  packets written, including truncated ones; wraps at 0xFFFF→0.
- len_err  out  1  one-cycle pulse when a packet is truncated.

## Operation
- States: IDLE, XFER. Reset: IDLE, every output 0, last_grant = NumSrc-1, word_cnt = 0.
- IDLE
  - If any src_valid is high, grant the first set bit searching from last_grant+1 modulo NumSrc. Load grant_id, set busy, go to XFER.
  - No word is accepted in IDLE, so the gap between packets is at least 1 cycle.
- Occupancy gate
  - occ = {fifo_wrfull, fifo_wrusedw} + fifo_wrreq, computed (RAMAddWidth+1) bits wide, range 0..17.
  - space_ok = (occ < 2^RAMAddWidth).
  - fifo_wrreq accounts for the write already in flight, because FIFO flags update one cycle after wrreq.
- XFER
  - src_ready[grant_id] = src_valid[grant_id] & space_ok. All other src_ready bits are 0.
  - On an accepted word, fifo_data <= the word and fifo_wrreq <= 1 on the next edge. Otherwise fifo_wrreq <= 0.
  - word_cnt increments on every accepted word.
  - Normal end: an accepted word with the last flag set → pkt_cnt+1, last_grant <= grant_id, word_cnt <= 0, busy <= 0, go to IDLE.
  - Truncation: an accepted word where word_cnt == MaxWords-1 and the last flag is clear → the written word has its last flag forced to 1, len_err pulses, pkt_cnt+1, and the state returns to IDLE as for a normal end. The rest of that source's words are arbitrated later as a new packet.
  - Granted source drops src_valid mid-packet → stay in XFER, keep the grant, write nothing. There is no timeout.
- Non-granted sources are never accepted, regardless of their src_valid.
- wr_aclr asserted mid-packet → immediate return to reset values. A partial packet already in the FIFO is not repaired; the FIFO is reset by the same wr_aclr.

## Timing
- Arbitration: src_valid high in IDLE at edge N → busy and grant_id valid after edge N; the first word can be accepted in cycle N+1.
- Write latency: word accepted in cycle N → fifo_wrreq/fifo_data valid in cycle N+1.
- Throughput: 1 word per cycle while space_ok holds. The packet rate is at most one packet per (length+1) cycles.
- Full boundary: usedw = 15 with fifo_wrreq = 1 gives occ = 16 → ready = 0. The FIFO never receives a write while it holds 16 words.
- Simultaneous last word and new requests: arbitration happens in the following IDLE cycle, using the updated last_grant.
- len_err, fifo_wrreq and pkt_cnt change only on wrclk edges.

## Test plan
- Single packet: src0 sends 3 words 0x001, 0x002, 0x103 with an empty FIFO → fifo_wrreq high for 3 consecutive cycles starting 2 cycles after valid, data matches, pkt_cnt = 1, busy low after the last word.
- Round robin: all 4 sources continuously present 2-word packets → grant order 0,1,2,3,0,1,…; after 8 packets each source has been served twice.
- Backpressure: fifo_wrusedw held at 15 with wrfull = 0 and no reads → at most 1 word written, then ready = 0. Releasing usedw to 10 resumes writes. No wrreq is ever issued while the modeled occupancy is 16.
- Truncation: MaxWords = 4, src1 streams 6 words with no last flag → 4th written word = data|0x100, len_err pulses once, pkt_cnt = 1, then src1 is re-granted for the remaining 2 words.
- Valid gap: the granted source drops valid for 5 cycles mid-packet while src2 is valid → no grant change, no writes, src_ready[2] = 0 throughout.
- Reset mid-packet: wr_aclr pulsed during the 2nd word → all outputs 0, state IDLE, next grant goes to source 0.
